// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life generation engine.
package gol_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        SWAP
    } gen_state_t;

    localparam int GEN_W = 16;

endpackage

// File: rtl/gol_row_next.sv
// Combinational next-generation row from a three-row window, columns wrap toroidally.
module gol_row_next #(
    parameter int K = 7
) (
    input  logic [(1<<K)-1:0] above_i,
    input  logic [(1<<K)-1:0] mid_i,
    input  logic [(1<<K)-1:0] below_i,
    output logic [(1<<K)-1:0] next_o
);

    localparam int N = 1 << K;

    always_comb begin
        next_o = '0;
        for (int c = 0; c < N; c++) begin
            logic [K-1:0] cc;
            logic [K-1:0] cl;
            logic [K-1:0] cr;
            logic [3:0]   n;
            cc = K'(c);
            cl = cc - K'(1);
            cr = cc + K'(1);
            n  = 4'(above_i[cl]) + 4'(above_i[cc]) + 4'(above_i[cr])
               + 4'(mid_i[cl])                     + 4'(mid_i[cr])
               + 4'(below_i[cl]) + 4'(below_i[cc]) + 4'(below_i[cr]);
            next_o[cc] = (n == 4'd3) | (mid_i[cc] & (n == 4'd2));
        end
    end

endmodule

// File: rtl/gol_gen_engine.sv
// Double-banked toroidal Life grid: edits/display on the current bank, one
// generation per change_state computed row-by-row into the other bank.
module gol_gen_engine
    import gol_pkg::*;
#(
    parameter int K = 7
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [K-1:0]     wAddrR,
    input  logic [K-1:0]     wAddrC,
    input  logic             write_en,
    input  logic             write_data,
    input  logic             change_state,
    input  logic [K-1:0]     rd_addrR,
    input  logic [K-1:0]     rd_addrC,
    output logic             rd_data,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count
);

    localparam int N  = 1 << K;
    localparam int CW = K + 1;

    logic [N-1:0] bank_a [N];
    logic [N-1:0] bank_b [N];

    gen_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cur_q;
    logic [GEN_W-1:0] gen_q;
    logic [N-1:0]     above_q, mid_q, below_q;
    logic             rd_data_q;

    logic             edit_we;
    logic             sweep_we;
    logic [K-1:0]     raddr;
    logic [K-1:0]     wrow;
    logic [N-1:0]     cur_row;
    logic [N-1:0]     new_row;

    assign edit_we  = (state_q == IDLE) && write_en;
    assign sweep_we = (state_q == SWEEP) && (cnt_q >= CW'(2));
    assign wrow     = K'(cnt_q - CW'(2));
    // Row N-1 is fetched on the edge that enters SWEEP, so the window is full two cycles in.
    assign raddr    = (state_q == SWEEP) ? K'(cnt_q) : '1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (change_state) state_d = SWEEP;
            end
            SWEEP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N + 1)) state_d = SWAP;
            end
            SWAP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bypass a same-edge edit into the first sweep fetch so it is seen by the step.
    always_comb begin
        cur_row = cur_q ? bank_b[raddr] : bank_a[raddr];
        if (edit_we && (wAddrR == raddr)) cur_row[wAddrC] = write_data;
    end

    gol_row_next #(.K(K)) u_row_next (
        .above_i (above_q),
        .mid_i   (mid_q),
        .below_i (below_q),
        .next_o  (new_row)
    );

    always_ff @(posedge clk) begin
        if (edit_we && !cur_q)       bank_a[wAddrR][wAddrC] <= write_data;
        else if (sweep_we && cur_q)  bank_a[wrow]           <= new_row;
    end

    always_ff @(posedge clk) begin
        if (edit_we && cur_q)        bank_b[wAddrR][wAddrC] <= write_data;
        else if (sweep_we && !cur_q) bank_b[wrow]           <= new_row;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_q     <= 1'b0;
            gen_q     <= '0;
            above_q   <= '0;
            mid_q     <= '0;
            below_q   <= '0;
            rd_data_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            below_q   <= cur_row;
            mid_q     <= below_q;
            above_q   <= mid_q;
            rd_data_q <= cur_q ? bank_b[rd_addrR][rd_addrC] : bank_a[rd_addrR][rd_addrC];
            if (state_q == SWAP) begin
                cur_q <= ~cur_q;
                gen_q <= gen_q + GEN_W'(1);
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = (state_q != IDLE);
    assign gen_count = gen_q;

endmodule

// File: tb/tb_gol_gen_engine.sv
// Bench for gol_gen_engine at K=3: pattern table plus mid-sweep and reset sequences.
module tb_gol_gen_engine;

    localparam int K = 3;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [K-1:0] wAddrR = '0;
    logic [K-1:0] wAddrC = '0;
    logic        write_en = 1'b0;
    logic        write_data = 1'b0;
    logic        change_state = 1'b0;
    logic [K-1:0] rd_addrR = '0;
    logic [K-1:0] rd_addrC = '0;
    logic        rd_data;
    logic        busy;
    logic [15:0] gen_count;

    gol_gen_engine #(.K(K)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .wAddrR       (wAddrR),
        .wAddrC       (wAddrC),
        .write_en     (write_en),
        .write_data   (write_data),
        .change_state (change_state),
        .rd_addrR     (rd_addrR),
        .rd_addrC     (rd_addrC),
        .rd_data      (rd_data),
        .busy         (busy),
        .gen_count    (gen_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] init;
        logic        cw_en;
        int          cw_r;
        int          cw_c;
        int          gens;
        logic [63:0] exp_g;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_gen = 0;
    logic exp_q[$];

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;

    function automatic logic [63:0] life_step(input logic [63:0] g);
        logic [63:0] nx;
        nx = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(g[((r + dr + N) % N) * N + ((c + dc + N) % N)]);
                nx[r * N + c] = (n == 3) || (g[r * N + c] && n == 2);
            end
        end
        return nx;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cell(input int r, input int c, input logic v);
        wAddrR     = K'(r);
        wAddrC     = K'(c);
        write_data = v;
        write_en   = 1'b1;
        tick();
        write_en   = 1'b0;
    endtask

    task automatic load(input logic [63:0] g);
        for (int i = 0; i < N * N; i++) write_cell(i / N, i % N, g[i]);
    endtask

    task automatic read_grid(input string name, input logic [63:0] g);
        for (int i = 0; i < N * N; i++) begin
            rd_addrR = K'(i / N);
            rd_addrC = K'(i % N);
            exp_q.push_back(g[i]);
            tick();
            check($sformatf("%s cell r%0d c%0d", name, i / N, i % N), 64'(rd_data), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy !== 1'b0 && cycles < 200) begin
            cycles++;
            tick();
        end
    endtask

    task automatic step(input string name, input logic cw_en, input int r, input int c);
        int cyc;
        change_state = 1'b1;
        if (cw_en) begin
            wAddrR     = K'(r);
            wAddrC     = K'(c);
            write_data = 1'b1;
            write_en   = 1'b1;
        end
        tick();
        change_state = 1'b0;
        write_en     = 1'b0;
        wait_idle(cyc);
        exp_gen++;
        check({name, " busy_len"}, 64'(cyc), 64'(N + 3));
        check({name, " gen_count"}, 64'(gen_count), 64'(exp_gen));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0] = '{"blinker1", BLINK_H, 1'b0, 0, 0, 1, BLINK_V};
        vecs[1] = '{"blinker2", BLINK_H, 1'b0, 0, 0, 2, BLINK_H};
        vecs[2] = '{"block3",   64'h0000_0000_0006_0600, 1'b0, 0, 0, 3, 64'h0000_0000_0006_0600};
        vecs[3] = '{"glider4",  64'h1008_0000_0000_001C, 1'b0, 0, 0, 4, 64'h1000_0000_0000_3820};
        vecs[4] = '{"coinc00",  64'h0000_0000_0000_0102, 1'b1, 0, 0, 1, 64'h0000_0000_0000_0303};
        vecs[5] = '{"coinc70",  64'h0200_0000_0000_0001, 1'b1, 7, 0, 1, 64'h0300_0000_0000_0003};
        for (int v = 6; v < 8; v++) begin
            vecs[v].name  = $sformatf("soup%0d", v);
            vecs[v].init  = {$urandom, $urandom};
            vecs[v].cw_en = 1'b0;
            vecs[v].cw_r  = 0;
            vecs[v].cw_c  = 0;
            vecs[v].gens  = 1;
            vecs[v].exp_g = life_step(vecs[v].init);
        end

        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset gen_count", 64'(gen_count), 64'd0);
        check("reset rd_data", 64'(rd_data), 64'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            load(vecs[v].init);
            read_grid({vecs[v].name, " loaded"}, vecs[v].init);
            for (int g = 0; g < vecs[v].gens; g++)
                step(vecs[v].name, (g == 0) && vecs[v].cw_en, vecs[v].cw_r, vecs[v].cw_c);
            read_grid(vecs[v].name, vecs[v].exp_g);
        end

        // Extra pulse and edit during the sweep are dropped; display shows the old grid.
        load(BLINK_H);
        change_state = 1'b1;
        tick();
        change_state = 1'b0;
        rd_addrR = 3'd3; rd_addrC = 3'd2; exp_q.push_back(1'b1);
        tick();
        check("midsweep rd 3,2", 64'(rd_data), 64'(exp_q.pop_front()));
        change_state = 1'b1;
        wAddrR = 3'd0; wAddrC = 3'd0; write_data = 1'b1; write_en = 1'b1;
        rd_addrR = 3'd2; rd_addrC = 3'd3; exp_q.push_back(1'b0);
        tick();
        change_state = 1'b0;
        write_en = 1'b0;
        check("midsweep rd 2,3", 64'(rd_data), 64'(exp_q.pop_front()));
        check("midsweep busy", 64'(busy), 64'd1);
        rd_addrR = 3'd3; rd_addrC = 3'd4; exp_q.push_back(1'b1);
        tick();
        check("midsweep rd 3,4", 64'(rd_data), 64'(exp_q.pop_front()));
        wait_idle(cyc);
        exp_gen++;
        check("midsweep gen_count", 64'(gen_count), 64'(exp_gen));
        repeat (5) tick();
        check("dropped pulse busy", 64'(busy), 64'd0);
        check("dropped pulse gen_count", 64'(gen_count), 64'(exp_gen));
        read_grid("midsweep result", BLINK_V);

        // Asynchronous reset in the middle of a step.
        load(BLINK_H);
        change_state = 1'b1;
        tick();
        change_state = 1'b0;
        repeat (3) tick();
        rst_b = 1'b0;
        #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset gen_count", 64'(gen_count), 64'd0);
        check("midreset rd_data", 64'(rd_data), 64'd0);
        exp_gen = 0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        tick();
        load(BLINK_H);
        step("postreset", 1'b0, 0, 0);
        read_grid("postreset", BLINK_V);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
